bht_ctrl: RTL

Controller that shares the single-index 2-bit-counter BHT between fetch-stage prediction lookups and execute-stage resolved-branch updates. Resolved updates are buffered in a small in-order queue and drained into the BHT in cycles where fetch does not need the index port. A starvation/full FSM forces draining so updates are never lost. The block sits between the fetch unit, the branch-resolution logic in execute, and the BHT instance.

---
 rtl/bht_pkg.sv | 17 +
 rtl/bht_ctrl_if.sv | 12 +
 rtl/bht_upd_fifo.sv | 62 ++++++
 rtl/bht_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared types and default sizes for the BHT lookup/update controller.
package bht_pkg;

   localparam int unsigned BHT_INDEX_WIDTH = 6;
   localparam int unsigned BHT_QUEUE_DEPTH = 4;

   typedef struct packed {
      logic [BHT_INDEX_WIDTH-1:0] index;
      logic                       taken;
   } bht_upd_t;

   typedef enum logic {
      NORMAL = 1'b0,
      DRAIN  = 1'b1
   } bht_ctrl_state_e;

endpackage

// File: rtl/bht_ctrl_if.sv
// Resolved-branch update channel: valid/ready handshake carrying a bht_upd_t.
interface bht_ctrl_if;
   import bht_pkg::*;

   logic     valid;
   logic     ready;
   bht_upd_t data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/bht_upd_fifo.sv
// In-order queue of resolved branch updates; pushes via the update channel, pops on drain grant.
module bht_upd_fifo
   import bht_pkg::*;
#(
   parameter int unsigned DEPTH = BHT_QUEUE_DEPTH,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_arst,
   bht_ctrl_if.slave        upd_if,
   input  logic             pop_i,
   output bht_upd_t         head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W:0]   count_o
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   bht_upd_t         mem_q [DEPTH];
   logic             push_c;
   logic             pop_c;

   assign full_o       = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o      = (count_q == '0);
   assign count_o      = count_q;
   assign upd_if.ready = ~full_o;
   assign head_o       = mem_q[rd_ptr_q];
   assign push_c       = upd_if.valid & ~full_o;
   assign pop_c        = pop_i & ~empty_o;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
      count_d  = count_q;
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge i_clk) begin
      if (push_c) mem_q[wr_ptr_q] <= upd_if.data;
   end

endmodule

// File: rtl/bht_ctrl.sv
// Arbitrates the single BHT index port between fetch lookups and queued execute updates.
// Optional statistics counters enabled by defining BHT_CTRL_STATS_EN.
module bht_ctrl
   import bht_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH  = BHT_INDEX_WIDTH,
   parameter int unsigned QUEUE_DEPTH  = BHT_QUEUE_DEPTH,
   parameter int unsigned PTR_W        = 2,
   parameter int unsigned STARVE_LIMIT = 8
`ifdef BHT_CTRL_STATS_EN
   ,
   parameter int unsigned STAT_W       = 32
`endif
) (
   input  logic                   i_clk,
   input  logic                   i_arst,
   input  logic                   i_lookup_req,
   input  logic [INDEX_WIDTH-1:0] i_lookup_index,
   output logic                   o_lookup_valid,
   output logic                   o_lookup_taken,
   output logic                   o_lookup_stall,
   input  logic                   i_upd_valid,
   input  logic [INDEX_WIDTH-1:0] i_upd_index,
   input  logic                   i_upd_taken,
   output logic                   o_upd_ready,
   output logic                   o_bht_update,
   output logic                   o_bht_branch_taken,
   output logic [INDEX_WIDTH-1:0] o_bht_set_index,
   input  logic                   i_bht_pred_taken,
   output logic                   o_queue_empty,
   output logic                   o_queue_full
`ifdef BHT_CTRL_STATS_EN
   ,
   output logic [STAT_W-1:0]      o_stat_lookups,
   output logic [STAT_W-1:0]      o_stat_updates,
   output logic [STAT_W-1:0]      o_stat_stalls
`endif
);

   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

   bht_ctrl_state_e      state_q, state_d;
   logic [STARVE_W-1:0]  starve_q, starve_d;
   logic [PTR_W:0]       q_count;
   logic                 q_full;
   logic                 q_empty;
   bht_upd_t             q_head;
   logic                 push_c;
   logic                 pop_c;
   logic                 starve_hit;

   bht_ctrl_if upd_bus ();

   assign upd_bus.valid = i_upd_valid;
   assign upd_bus.data  = '{index: BHT_INDEX_WIDTH'(i_upd_index), taken: i_upd_taken};
   assign o_upd_ready   = upd_bus.ready;
   assign push_c        = i_upd_valid & upd_bus.ready;
   assign o_queue_empty = q_empty;
   assign o_queue_full  = q_full;
   assign starve_hit    = (starve_q == STARVE_W'(STARVE_LIMIT));

   bht_upd_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_arst  (i_arst),
      .upd_if  (upd_bus.slave),
      .pop_i   (pop_c),
      .head_o  (q_head),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (q_count)
   );

   // Port arbitration and next state; the index port defaults to fetch when idle.
   always_comb begin
      state_d            = state_q;
      o_lookup_valid     = 1'b0;
      o_lookup_taken     = 1'b0;
      o_lookup_stall     = 1'b0;
      o_bht_update       = 1'b0;
      o_bht_branch_taken = 1'b0;
      o_bht_set_index    = i_lookup_index;
      pop_c              = 1'b0;
      case (state_q)
         NORMAL: begin
            if (i_lookup_req) begin
               o_lookup_valid = 1'b1;
               o_lookup_taken = i_bht_pred_taken;
            end else if (!q_empty) begin
               pop_c = 1'b1;
            end
            if (q_full || starve_hit) state_d = DRAIN;
         end
         DRAIN: begin
            o_lookup_stall = i_lookup_req;
            pop_c          = ~q_empty;
            if (q_empty || (q_count == (PTR_W+1)'(1) && !push_c)) state_d = NORMAL;
         end
         default: state_d = NORMAL;
      endcase
      if (pop_c) begin
         o_bht_update       = 1'b1;
         o_bht_branch_taken = q_head.taken;
         o_bht_set_index    = INDEX_WIDTH'(q_head.index);
      end
   end

   // Waiting-cycle counter for a non-empty queue that fetch keeps starving.
   always_comb begin
      starve_d = starve_q;
      if (q_empty || pop_c)  starve_d = '0;
      else if (!starve_hit)  starve_d = starve_q + STARVE_W'(1);
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q  <= NORMAL;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

`ifdef BHT_CTRL_STATS_EN
   logic [STAT_W-1:0] stat_lookups_q, stat_updates_q, stat_stalls_q;

   assign o_stat_lookups = stat_lookups_q;
   assign o_stat_updates = stat_updates_q;
   assign o_stat_stalls  = stat_stalls_q;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         stat_lookups_q <= '0;
         stat_updates_q <= '0;
         stat_stalls_q  <= '0;
      end else begin
         stat_lookups_q <= stat_lookups_q + STAT_W'(o_lookup_valid);
         stat_updates_q <= stat_updates_q + STAT_W'(o_bht_update);
         stat_stalls_q  <= stat_stalls_q + STAT_W'(o_lookup_stall);
      end
   end
`endif

endmodule
